// File: rtl/mul_seq_64.sv
// Sequential RV64M multiplier (MUL/MULH/MULHSU/MULHU): shift-and-add over one shared 64-bit CLA.
// Optional build macro MUL_SEQ_STATS_EN adds a saturating completed-operation counter (stat_ops).

module CLA_64bit (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin,
    output logic [63:0] Sum,
    output logic        Cout,
    output logic        Overflow
);
    logic [63:0] p;
    logic [63:0] g;
    logic [63:0] c;
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [16:0] gc;

    assign p = A ^ B;
    assign g = A & B;

    // 4-bit lookahead groups; carries inside a group only depend on the group carry-in
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_grp
            localparam int B0 = gi * 4;
            assign c[B0]     = gc[gi];
            assign c[B0 + 1] = g[B0] | (p[B0] & gc[gi]);
            assign c[B0 + 2] = g[B0 + 1] | (p[B0 + 1] & g[B0])
                             | (p[B0 + 1] & p[B0] & gc[gi]);
            assign c[B0 + 3] = g[B0 + 2] | (p[B0 + 2] & g[B0 + 1])
                             | (p[B0 + 2] & p[B0 + 1] & g[B0])
                             | (p[B0 + 2] & p[B0 + 1] & p[B0] & gc[gi]);
            assign grp_g[gi] = g[B0 + 3] | (p[B0 + 3] & g[B0 + 2])
                             | (p[B0 + 3] & p[B0 + 2] & g[B0 + 1])
                             | (p[B0 + 3] & p[B0 + 2] & p[B0 + 1] & g[B0]);
            assign grp_p[gi] = &p[B0 + 3:B0];
        end
    endgenerate

    always_comb begin
        gc[0] = Cin;
        for (int i = 0; i < 16; i++) begin
            gc[i + 1] = grp_g[i] | (grp_p[i] & gc[i]);
        end
    end

    assign Sum      = p ^ c;
    assign Cout     = gc[16];
    assign Overflow = c[63] ^ gc[16];
endmodule

module mul_seq_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        ready,
    output logic        done,
`ifdef MUL_SEQ_STATS_EN
    output logic [31:0] stat_ops,
`endif
    output logic [63:0] result
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NEG_A  = 3'd1;
    localparam logic [2:0] ST_NEG_B  = 3'd2;
    localparam logic [2:0] ST_MUL    = 3'd3;
    localparam logic [2:0] ST_FIX_LO = 3'd4;
    localparam logic [2:0] ST_FIX_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] m_q, m_d;
    logic [63:0] hi_q, hi_d;
    logic [63:0] lo_q, lo_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        neg_res_q, neg_res_d;
    logic        carry_q, carry_d;
    logic [63:0] result_q, result_d;

    logic [63:0] add_a;
    logic [63:0] add_b;
    logic        add_cin;
    logic [63:0] add_sum;
    logic        add_cout;
    logic        adder_ovf_unused;

    CLA_64bit u_cla (
        .A        (add_a),
        .B        (add_b),
        .Cin      (add_cin),
        .Sum      (add_sum),
        .Cout     (add_cout),
        .Overflow (adder_ovf_unused)
    );

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

    // Adder operand steering; negation passes run every time even when the result is discarded
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_NEG_A:  begin add_a = ~m_q;  add_cin = 1'b1;    end
            ST_NEG_B:  begin add_a = ~lo_q; add_cin = 1'b1;    end
            ST_MUL:    begin add_a = hi_q;  add_b   = m_q;     end
            ST_FIX_LO: begin add_a = ~lo_q; add_cin = 1'b1;    end
            ST_FIX_HI: begin add_a = ~hi_q; add_cin = carry_q; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        neg_res_d = neg_res_q;
        carry_d   = carry_q;
        result_d  = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_NEG_A;
                        cnt_d     = '0;
                        op_d      = op;
                        m_d       = a;
                        lo_d      = b;
                        hi_d      = '0;
                        sign_a_d  = a[63] & (op[0] ^ op[1]);
                        sign_b_d  = b[63] & (op == OP_MULH);
                        neg_res_d = (a[63] & (op[0] ^ op[1])) ^ (b[63] & (op == OP_MULH));
                    end else if (state_q == ST_DONE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_NEG_A: begin
                    if (sign_a_q) m_d = add_sum;
                    state_d = ST_NEG_B;
                end
                ST_NEG_B: begin
                    if (sign_b_q) lo_d = add_sum;
                    state_d = ST_MUL;
                end
                ST_MUL: begin
                    if (lo_q[0]) begin
                        hi_d = {add_cout, add_sum[63:1]};
                        lo_d = {add_sum[0], lo_q[63:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[63:1]};
                        lo_d = {hi_q[0], lo_q[63:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_d = ST_FIX_LO;
                end
                ST_FIX_LO: begin
                    if (neg_res_q) lo_d = add_sum;
                    carry_d = add_cout;
                    state_d = ST_FIX_HI;
                end
                ST_FIX_HI: begin
                    if (neg_res_q) hi_d = add_sum;
                    result_d = (op_q == OP_MUL) ? lo_q : (neg_res_q ? add_sum : hi_q);
                    state_d  = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            neg_res_q <= 1'b0;
            carry_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            neg_res_q <= neg_res_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
        end
    end

`ifdef MUL_SEQ_STATS_EN
    logic [31:0] stat_q, stat_d;

    // A flush only aborts work before DONE, so counting DONE cycles excludes flushed ops
    always_comb begin
        stat_d = stat_q;
        if ((state_q == ST_DONE) && (stat_q != 32'hFFFF_FFFF)) stat_d = stat_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_ops = stat_q;
`endif
endmodule

// File: tb/tb_mul_seq_64.sv
// Directed self-checking bench for mul_seq_64: vector table plus back-to-back, flush and reset sequences.
`timescale 1ns/1ps

module tb_mul_seq_64;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        ready;
    logic        done;
    logic [63:0] result;
`ifdef MUL_SEQ_STATS_EN
    logic [31:0] stat_ops;
`endif

    int checks = 0;
    int fails  = 0;
    int completed = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [12];

    mul_seq_64 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .ready  (ready),
        .done   (done),
`ifdef MUL_SEQ_STATS_EN
        .stat_ops (stat_ops),
`endif
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%h", nm, act);
        end
    endtask

    task automatic run_vec(input string nm, input logic [1:0] vop, input logic [63:0] va,
                           input logic [63:0] vb, input logic [63:0] exp);
        int edges;
        @(negedge clk);
        op = vop; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " ready_low"}, 64'(ready), 64'd0);
        edges = 0;
        while (!done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        if (done) completed++;
        chk({nm, " latency"}, 64'(edges), 64'd68);
        chk({nm, " result"}, result, exp);
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int dones;
        vecs[0]  = '{2'b00, 64'd3, 64'd5, 64'hF};
        vecs[1]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[2]  = '{2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[3]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1};
        vecs[4]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[6]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[7]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[9]  = '{2'b10, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[10] = '{2'b00, 64'h1234_5678, 64'h1000, 64'h0000_0123_4567_8000};
        vecs[11] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back: start held high through the first DONE cycle
        @(negedge clk);
        op = 2'b00; a = 64'd3; b = 64'd5; start = 1'b1;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (done) completed++;
        t = 0;
        @(negedge clk);
        t = 1;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (done) completed++;
        chk("b2b spacing", 64'(t), 64'd69);
        chk("b2b result", result, 64'hF);
        @(negedge clk);
        chk("b2b idle ready", 64'(ready), 64'd1);
        chk("b2b idle done", 64'(done), 64'd0);

        // Flush 30 cycles after accept, with a competing start
        op = 2'b11; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush ready", 64'(ready), 64'd1);
        chk("flush done", 64'(done), 64'd0);
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("flush no_done", 64'(dones), 64'd0);
        chk("flush result_held", result, 64'hF);
`ifdef MUL_SEQ_STATS_EN
        chk("stat_ops count", 64'(stat_ops), 64'(completed));
`endif

        // Reset mid-MUL
        op = 2'b01; a = 64'hFFFF_FFFF_FFFF_FFFD; b = 64'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst result", result, 64'd0);
`ifdef MUL_SEQ_STATS_EN
        chk("rst stat_ops", 64'(stat_ops), 64'd0);
`endif
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst no_done", 64'(dones), 64'd0);

        run_vec("post_rst", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
